// File: rtl/aes_pkg.sv
// Shared AES datapath constants, the sequential SubBytes FSM encoding and slice addressing.
// Pure definitions; no timing or flow-control behaviour lives here.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = AES_STATE_W / AES_BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    // Slice 0 is the most significant group of lanes bytes, so offsets shrink as k grows.
    function automatic logic [6:0] slice_lsb(input int k, input int lanes);
        slice_lsb = 7'((AES_NBYTES - (k + 1) * lanes) * AES_BYTE_W);
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box, one byte, purely combinational lookup.
// Zero latency; no handshake.
module inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry i occupies bits [2047-8*i -: 8], so the first row sits in the top 128 bits.
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
        128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
        128'h547b9432_a6c2233d_ee4c950b_42fac34e,
        128'h082ea166_28d924b2_765ba249_6d8bd125,
        128'h72f8f664_86689816_d4a45ccc_5d65b692,
        128'h6c704850_fdedb9da_5e154657_a78d9d84,
        128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
        128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
        128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
        128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
        128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
        128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
        128'h1fdda833_8807c731_b1121059_2780ec5f,
        128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
        128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
        128'h172b047e_ba77d626_e1691463_55210c7d
    };

    logic [10:0] tbl_idx;

    assign tbl_idx  = {~in_byte, 3'b000};
    assign out_byte = INV_SBOX_TBL[tbl_idx +: 8];

endmodule

// File: rtl/inv_subbytes_seq.sv
// Time-multiplexed inverse SubBytes: LANES bytes per cycle, 16/LANES RUN cycles after accept.
// Result held in DONE until out_ready; a new state may be accepted on the releasing edge.
module inv_subbytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int NCYC = AES_NBYTES / LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int SW   = LANES * AES_BYTE_W;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

    fsm_state_e      state_q, state_d;
    logic [127:0]    st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [6:0]      slice_off;
    logic [SW-1:0]   slice_in;
    logic [SW-1:0]   slice_out;

    assign slice_off = slice_lsb(int'(cnt_q), LANES);
    assign slice_in  = st_q[slice_off +: SW];

    for (genvar g = 0; g < LANES; g++) begin : g_box
        inv_sbox u_inv_sbox (
            .in_byte  (slice_in[g*AES_BYTE_W +: AES_BYTE_W]),
            .out_byte (slice_out[g*AES_BYTE_W +: AES_BYTE_W])
        );
    end

    always_comb begin
        state_d  = state_q;
        st_d     = st_q;
        cnt_d    = cnt_q;
        in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    st_d    = in_data;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                st_d[slice_off +: SW] = slice_out;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                // Releasing the result and accepting the next state share one edge.
                if (out_ready) begin
                    if (in_valid) begin
                        st_d    = in_data;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            st_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = st_q;

endmodule
